// File: rtl/mem_delay_pkg.sv
// Shared constants and helpers for the multi-channel memory delay timer.
// Holds the LFSR definition, the mode encoding and the per-channel state type.
package mem_delay_pkg;

    localparam logic        MODE_FIXED   = 1'b0;
    localparam logic        MODE_RAND    = 1'b1;
    localparam int          LFSR_W       = 16;
    localparam logic [15:0] LFSR_POLY    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    typedef enum logic {CH_IDLE = 1'b0, CH_RUN = 1'b1} chan_state_t;

    // Right-shifting Galois form: feedback taps are XORed in when bit 0 falls out.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_POLY) : (v >> 1);
    endfunction

    function automatic logic [LFSR_W-1:0] rotl(input logic [LFSR_W-1:0] v, input int k);
        logic [2*LFSR_W-1:0] d;
        d = {v, v} << (k % LFSR_W);
        return d[2*LFSR_W-1 -: LFSR_W];
    endfunction

endpackage

// File: rtl/mem_delay_chan.sv
// One delay channel: IDLE/RUN state, cycle counter and latched bound.
// A zero bound is promoted to one so every start produces a done pulse.
module mem_delay_chan
    import mem_delay_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cancel,
    input  logic [CNT_W-1:0] bound_in,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] remain
);

    chan_state_t      state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] bound;

    always_ff @(posedge clk) begin
        if (rst) state <= CH_IDLE;
        else     state <= state_nxt;
    end

    // Start takes priority over cancel and over completion (restart semantics).
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            bound <= '0;
        end else if (start) begin
            cnt   <= '0;
            bound <= (bound_in == '0) ? CNT_W'(1) : bound_in;
        end else if (state == CH_RUN && !cancel && !done) begin
            cnt <= cnt + CNT_W'(1);
        end else begin
            cnt <= '0;
        end
    end

    always_comb begin
        state_nxt = state;
        if (start)
            state_nxt = CH_RUN;
        else if (state == CH_RUN && (cancel || done))
            state_nxt = CH_IDLE;
    end

    always_comb begin
        busy   = (state == CH_RUN);
        done   = busy && (cnt == bound - CNT_W'(1));
        remain = busy ? (bound - CNT_W'(1) - cnt) : '0;
    end

endmodule

// File: rtl/mem_delay_timer.sv
// Multi-channel programmable delay timer for memory latency emulation.
// Holds the shared LFSR, picks fixed or random bounds and fans out to channels.
module mem_delay_timer
    import mem_delay_pkg::*;
#(
    parameter int          NCH   = 2,
    parameter int          CNT_W = 8,
    parameter logic [15:0] SEED  = DEFAULT_SEED
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NCH-1:0]       i_start,
    input  logic [NCH-1:0]       i_cancel,
    input  logic [NCH-1:0]       i_mode,
    input  logic [NCH*CNT_W-1:0] i_bound,
    input  logic [CNT_W-1:0]     i_rand_mask,
    output logic [NCH-1:0]       o_busy,
    output logic [NCH-1:0]       o_done,
    output logic [NCH*CNT_W-1:0] o_remain
);

    logic [LFSR_W-1:0] lfsr;

    always_ff @(posedge i_clk) begin
        if (i_rst) lfsr <= SEED;
        else       lfsr <= lfsr_step(lfsr);
    end

    // Each channel sees the LFSR rotated by its index so simultaneous starts differ.
    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [CNT_W-1:0] rnd;
        logic [CNT_W-1:0] bsel;

        assign rnd  = CNT_W'(rotl(lfsr, k)) & i_rand_mask;
        assign bsel = (i_mode[k] == MODE_RAND) ? rnd : i_bound[k*CNT_W +: CNT_W];

        mem_delay_chan #(.CNT_W(CNT_W)) u_chan (
            .clk      (i_clk),
            .rst      (i_rst),
            .start    (i_start[k]),
            .cancel   (i_cancel[k]),
            .bound_in (bsel),
            .busy     (o_busy[k]),
            .done     (o_done[k]),
            .remain   (o_remain[k*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_mem_delay_timer.sv
// Self-checking bench for mem_delay_timer: deadline-based model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_mem_delay_timer;

    localparam int NCH   = 2;
    localparam int CNT_W = 8;

    logic                 clk = 1'b0;
    logic                 i_rst;
    logic [NCH-1:0]       i_start, i_cancel, i_mode;
    logic [NCH*CNT_W-1:0] i_bound;
    logic [CNT_W-1:0]     i_rand_mask;
    logic [NCH-1:0]       o_busy, o_done;
    logic [NCH*CNT_W-1:0] o_remain;

    always #5 clk = ~clk;

    mem_delay_timer #(.NCH(NCH), .CNT_W(CNT_W), .SEED(16'hACE1)) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_cancel    (i_cancel),
        .i_mode      (i_mode),
        .i_bound     (i_bound),
        .i_rand_mask (i_rand_mask),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_remain    (o_remain)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: each channel is a deadline ----------------
    int          cyc = 0;
    bit          armed = 1'b0;
    bit          m_act [NCH];
    int          m_st  [NCH];
    int          m_dl  [NCH];
    logic [15:0] m_lfsr;

    function automatic logic [15:0] m_rotl(input logic [15:0] v, input int k);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < k; i++) r = {r[14:0], r[15]};
        return r;
    endfunction

    function automatic int eff_bound(input int k);
        int b;
        if (i_mode[k]) b = int'(m_rotl(m_lfsr, k) & 16'(i_rand_mask));
        else           b = int'(i_bound[k*CNT_W +: CNT_W]);
        return (b == 0) ? 1 : b;
    endfunction

    always @(posedge clk) begin
        if (i_rst) begin
            for (int k = 0; k < NCH; k++) m_act[k] <= 1'b0;
            m_lfsr <= 16'hACE1;
            armed  <= 1'b1;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (i_start[k]) begin
                    m_act[k] <= 1'b1;
                    m_st[k]  <= cyc;
                    m_dl[k]  <= cyc + eff_bound(k);
                end else if (m_act[k] && (i_cancel[k] || cyc >= m_dl[k])) begin
                    m_act[k] <= 1'b0;
                end
            end
            m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
        end
        cyc <= cyc + 1;
    end

    function automatic bit exp_busy(input int k);
        return m_act[k] && cyc > m_st[k] && cyc <= m_dl[k];
    endfunction

    always @(negedge clk) begin
        if (armed) begin
            for (int k = 0; k < NCH; k++) begin
                check($sformatf("model_busy%0d", k), 32'(o_busy[k]), 32'(exp_busy(k)));
                check($sformatf("model_done%0d", k), 32'(o_done[k]),
                      32'(m_act[k] && cyc == m_dl[k]));
                check($sformatf("model_remain%0d", k), 32'(o_remain[k*CNT_W +: CNT_W]),
                      exp_busy(k) ? 32'(m_dl[k] - cyc) : 32'd0);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_ch(input int ch, input logic mode, input logic [CNT_W-1:0] b);
        i_start[ch] = 1'b1;
        i_mode[ch]  = mode;
        i_bound[ch*CNT_W +: CNT_W] = b;
        step();
        i_start[ch] = 1'b0;
    endtask

    function automatic logic [31:0] rem(input int k);
        return 32'(o_remain[k*CNT_W +: CNT_W]);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int d0, d1;
        i_rst = 1'b1; i_start = '0; i_cancel = '0; i_mode = '0;
        i_bound = '0; i_rand_mask = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(o_busy), 0);
        check("rst_done", 32'(o_done), 0);
        check("rst_remain", 32'(o_remain), 0);
        i_rst = 1'b0;
        step();

        // fixed bound 5: remain 4..0, done only at t=5
        start_ch(0, 1'b0, 8'd5);
        for (int i = 1; i <= 6; i++) begin
            check($sformatf("fix_busy_t%0d", i), 32'(o_busy[0]), (i <= 5) ? 1 : 0);
            check($sformatf("fix_done_t%0d", i), 32'(o_done[0]), (i == 5) ? 1 : 0);
            check($sformatf("fix_rem_t%0d", i), rem(0), (i <= 5) ? 32'(5 - i) : 0);
            step();
        end

        // zero and one bounds on ch1
        for (int b = 0; b <= 1; b++) begin
            start_ch(1, 1'b0, 8'(b));
            check($sformatf("b%0d_done", b), 32'(o_done[1]), 1);
            check($sformatf("b%0d_busy", b), 32'(o_busy[1]), 1);
            step();
            check($sformatf("b%0d_idle", b), 32'(o_busy[1]), 0);
            step();
        end

        // restart: B=8 at t0, B=2 at t3 -> single done at t5
        start_ch(0, 1'b0, 8'd8);
        step(); step();
        start_ch(0, 1'b0, 8'd2);
        check("rs_rem_t4", rem(0), 1);
        step();
        check("rs_done_t5", 32'(o_done[0]), 1);
        step();
        check("rs_idle_t6", 32'(o_busy[0]), 0);
        repeat (6) step();

        // start in done cycle: both dones emitted
        start_ch(0, 1'b0, 8'd3);
        step(); step();
        check("rd_done_t3", 32'(o_done[0]), 1);
        start_ch(0, 1'b0, 8'd2);
        check("rd_busy_t4", 32'(o_busy[0]), 1);
        step();
        check("rd_done_t5", 32'(o_done[0]), 1);
        step();

        // cancel mid-count
        start_ch(0, 1'b0, 8'd6);
        step();
        i_cancel[0] = 1'b1;
        step();
        i_cancel[0] = 1'b0;
        check("cx_busy_t3", 32'(o_busy[0]), 0);
        check("cx_rem_t3", rem(0), 0);
        repeat (6) step();

        // cancel + start same cycle: restart wins
        start_ch(0, 1'b0, 8'd6);
        step();
        i_cancel[0] = 1'b1;
        start_ch(0, 1'b0, 8'd2);
        i_cancel[0] = 1'b0;
        check("cs_busy", 32'(o_busy[0]), 1);
        check("cs_rem", rem(0), 1);
        step();
        check("cs_done", 32'(o_done[0]), 1);
        step();

        // cancel while idle
        i_cancel = '1;
        step();
        i_cancel = '0;
        check("ci_busy", 32'(o_busy), 0);

        // reset mid-count on B=10, 3 cycles, no done ever
        start_ch(0, 1'b0, 8'd10);
        step(); step();
        i_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rm_busy", 32'(o_busy), 0);
            check("rm_done", 32'(o_done), 0);
            check("rm_remain", 32'(o_remain), 0);
        end
        // LFSR is ACE1 in the release cycle: ch0 B=E1&F=1, ch1 B=59C3&F=3
        i_rst = 1'b0; i_mode = '1; i_rand_mask = 8'h0F; i_start = '1;
        step();
        i_start = '0;
        check("seed_done0", 32'(o_done[0]), 1);
        check("seed_rem1", rem(1), 2);
        step(); step();
        check("seed_done1", 32'(o_done[1]), 1);
        step();

        // random mode: 1000 starts on both channels, delays in 1..15
        for (int it = 0; it < 1000; it++) begin
            repeat ($urandom_range(0, 3)) step();
            i_mode = '1; i_rand_mask = 8'h0F; i_start = '1;
            step();
            i_start = '0;
            d0 = 0; d1 = 0;
            for (int n = 1; n <= 20 && (d0 == 0 || d1 == 0); n++) begin
                if (o_done[0] && d0 == 0) d0 = n;
                if (o_done[1] && d1 == 0) d1 = n;
                step();
            end
            check("rand_range0", 32'(d0 >= 1 && d0 <= 15), 1);
            check("rand_range1", 32'(d1 >= 1 && d1 <= 15), 1);
        end

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
